umul_sched: RTL and testbench

UMUL_SCHED -- requirements
Module: umul_sched

---
 rtl/umul_pkg.sv | 31 +++
 rtl/umul_iter.sv | 73 +++++++
 rtl/umul_sched.sv | 142 ++++++++++++++
 tb/tb_umul_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/umul_pkg.sv
// -----------------------------------------------------------------------------
// umul_pkg
//   Shared definitions for the time-shared unsigned multiplier scheduler.
//   - umul_state_e : scheduler FSM states (IDLE, MUL, DONE)
//   - sat_low()    : clamps the low half of a product to all-ones when the
//                    high half is non-zero
// -----------------------------------------------------------------------------
package umul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } umul_state_e;

  // Widest operand the saturation helper handles; callers zero-extend into
  // this width and truncate the result back to their own width.
  localparam int SAT_MAX_W = 64;

  // Returns the low w bits of 'lo', or w ones when the high half was non-zero.
  function automatic logic [SAT_MAX_W-1:0] sat_low(
    input logic [SAT_MAX_W-1:0] lo,
    input logic                 hi_nz,
    input int unsigned          w
  );
    logic [SAT_MAX_W-1:0] ones;
    ones = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    return hi_nz ? ones : lo;
  endfunction

endpackage

// File: rtl/umul_iter.sv
// -----------------------------------------------------------------------------
// umul_iter
//   Iterative unsigned shift-add multiplier datapath. One partial product is
//   added per 'step' cycle; the accumulator is 2*DATA_WIDTH bits so it can
//   never wrap.
//
//   Configuration macro: UMUL_SCHED_EARLY_EXIT_EN
//     undefined : 'last' asserts on the DATA_WIDTH-th step
//     defined   : 'last' asserts on the step after which the shifted
//                 multiplier is zero (at least one step)
//
//   Ports
//     clk, rst   : clock, asynchronous active-high reset
//     load       : capture operands, clear accumulator and step count
//     step       : perform one shift-add iteration
//     mcand_in   : multiplicand
//     mplier_in  : multiplier
//     acc_next   : accumulator value after the current step
//     last       : current step is the final one
// -----------------------------------------------------------------------------
module umul_iter
  import umul_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      step,
  input  logic [DATA_WIDTH-1:0]     mcand_in,
  input  logic [DATA_WIDTH-1:0]     mplier_in,
  output logic [2*DATA_WIDTH-1:0]   acc_next,
  output logic                      last
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [CNT_W-1:0]        count;
  logic [2*DATA_WIDTH-1:0] partial;

  always_comb begin
    partial  = mplier[0] ? ({{DATA_WIDTH{1'b0}}, mcand} << count) : '0;
    acc_next = acc + partial;
`ifdef UMUL_SCHED_EARLY_EXIT_EN
    // Remaining multiplier bits all zero: nothing more to add.
    last     = (mplier[DATA_WIDTH-1:1] == '0);
`else
    last     = (count == CNT_W'(DATA_WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/umul_sched.sv
// -----------------------------------------------------------------------------
// umul_sched
//   Round-robin scheduler sharing one iterative unsigned multiplier among
//   NUM_REQ requesters. FSM: IDLE (arbitrate/accept) -> MUL (iterate) ->
//   DONE (hold response until rsp_ready).
//
//   Configuration macro: UMUL_SCHED_EARLY_EXIT_EN (see umul_iter)
//
//   Ports
//     clk, rst      : clock, asynchronous active-high reset
//     req_valid     : per-requester request
//     req_ready     : one-hot accept, only in IDLE
//     req_in0/1     : packed per-requester multiplicand / multiplier
//     rsp_valid     : response held until rsp_ready
//     rsp_ready     : consumer accepts response
//     rsp_id        : requester owning the response
//     rsp_out       : low half of product, saturated to all-ones on overflow
//     rsp_overflow  : high half of product
//     rsp_sig_ov    : high half non-zero
// -----------------------------------------------------------------------------
module umul_sched
  import umul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_in0,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_in1,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_out,
  output logic [DATA_WIDTH-1:0]           rsp_overflow,
  output logic                            rsp_sig_ov
);

  localparam int ID_W = $clog2(NUM_REQ);

  umul_state_e             state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         cur_id;
  logic [ID_W-1:0]         win_id;
  logic [ID_W-1:0]         rr_next;
  logic [ID_W:0]           idx_w;
  logic                    any_vld;
  logic                    accept;
  logic                    mul_last;
  logic [2*DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0]   prod_hi;
  logic [DATA_WIDTH-1:0]   prod_lo;
  logic                    prod_ov;
  logic [DATA_WIDTH-1:0]   prod_sat;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    any_vld = 1'b0;
    win_id  = '0;
    idx_w   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_w = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx_w >= (ID_W+1)'(NUM_REQ)) idx_w = idx_w - (ID_W+1)'(NUM_REQ);
      if (!any_vld && req_valid[idx_w[ID_W-1:0]]) begin
        any_vld = 1'b1;
        win_id  = idx_w[ID_W-1:0];
      end
    end
  end

  assign accept  = (state == IDLE) && any_vld && !rst;
  assign rr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  umul_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (state == MUL),
    .mcand_in  (req_in0[win_id*DATA_WIDTH +: DATA_WIDTH]),
    .mplier_in (req_in1[win_id*DATA_WIDTH +: DATA_WIDTH]),
    .acc_next  (acc_next),
    .last      (mul_last)
  );

  assign prod_hi  = acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
  assign prod_lo  = acc_next[DATA_WIDTH-1:0];
  assign prod_ov  = |prod_hi;
  assign prod_sat = DATA_WIDTH'(sat_low(SAT_MAX_W'(prod_lo), prod_ov, DATA_WIDTH));

  // Response fields are captured from the final accumulator value on the
  // last MUL cycle, so they are registered and stable throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cur_id       <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_out      <= '0;
      rsp_overflow <= '0;
      rsp_sig_ov   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_id <= win_id;
            rr_ptr <= rr_next;
            state  <= MUL;
          end
        end
        MUL: begin
          if (mul_last) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= cur_id;
            rsp_out      <= prod_sat;
            rsp_overflow <= prod_hi;
            rsp_sig_ov   <= prod_ov;
            state        <= DONE;
          end
        end
        DONE: begin
          // Always pass through IDLE after a handshake; no same-cycle re-accept.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umul_sched.sv
// -----------------------------------------------------------------------------
// tb_umul_sched
//   Directed self-checking bench for umul_sched (DATA_WIDTH=8, NUM_REQ=4).
//   Expected results are hand-computed products.
// -----------------------------------------------------------------------------
module tb_umul_sched;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

`ifdef UMUL_SCHED_EARLY_EXIT_EN
  localparam int LAT_SHORT = 2;
`else
  localparam int LAT_SHORT = 9;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_in0;
  logic [NR*DW-1:0]  req_in1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_out;
  logic [DW-1:0]     rsp_overflow;
  logic              rsp_sig_ov;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  umul_sched #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_in0      (req_in0),
    .req_in1      (req_in1),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_out      (rsp_out),
    .rsp_overflow (rsp_overflow),
    .rsp_sig_ov   (rsp_sig_ov)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic check_rsp(input int id, input logic [7:0] e_out,
                           input logic [7:0] e_ovf, input logic e_sig);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id", rsp_id, id);
    check("rsp_out", rsp_out, e_out);
    check("rsp_overflow", rsp_overflow, e_ovf);
    check("rsp_sig_ov", rsp_sig_ov, e_sig);
  endtask

  // Single request on requester 'id' that must win immediately.
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                        input int exp_lat, input logic [7:0] e_out,
                        input logic [7:0] e_ovf, input logic e_sig);
    int lat;
    req_in0[id*DW +: DW] = a;
    req_in1[id*DW +: DW] = b;
    req_valid = NR'(1 << id);
    #1;
    check("grant", req_ready, 32'(1 << id));
    tick;
    req_valid = '1;
    #1;
    check("busy_ready", req_ready, 0);
    req_valid = '0;
    wait_rsp(lat);
    check("latency", lat, exp_lat);
    check_rsp(id, e_out, e_ovf, e_sig);
    tick;
    check("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    int lat;
    int n;
    int prev;
    int seen;
    req_valid = '1;
    req_in0   = '0;
    req_in1   = '0;
    rsp_ready = 1'b1;
    prev      = 0;
    tick;
    tick;

    // Reset state
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_out", rsp_out, 0);
    check("rst_rsp_overflow", rsp_overflow, 0);
    check("rst_rsp_sig_ov", rsp_sig_ov, 0);
    req_valid = '0;
    rst = 1'b0;
    tick;

    // Basic products: 195, 0xFE01, 0x100, 0, 255
    run_op(0, 8'd15,  8'd13,  9,         8'd195, 8'h00, 1'b0);
    run_op(1, 8'd255, 8'd255, 9,         8'hFF,  8'hFE, 1'b1);
    run_op(2, 8'd2,   8'h80,  9,         8'hFF,  8'h01, 1'b1);
    run_op(3, 8'd200, 8'd0,   LAT_SHORT, 8'h00,  8'h00, 1'b0);
    run_op(0, 8'd255, 8'd1,   LAT_SHORT, 8'hFF,  8'h00, 1'b0);

    // Back-pressure: 10*148 = 0x5C8 held while rsp_ready low; req2 waits
    req_in0[1*DW +: DW] = 8'd10;
    req_in1[1*DW +: DW] = 8'h94;
    req_in0[2*DW +: DW] = 8'd3;
    req_in1[2*DW +: DW] = 8'h81;
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("bp_grant", req_ready, 4'b0010);
    tick;
    req_valid = 4'b0100;
    wait_rsp(lat);
    check("bp_latency", lat, 9);
    for (int k = 0; k < 5; k++) begin
      check_rsp(1, 8'hFF, 8'h05, 1'b1);
      check("bp_ready", req_ready, 0);
      tick;
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_valid", rsp_valid, 1);
    check("hs_ready", req_ready, 0);
    tick;
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_grant", req_ready, 4'b0100);
    tick;
    req_valid = '0;
    wait_rsp(lat);
    check("req2_latency", lat, 9);
    check_rsp(2, 8'hFF, 8'h01, 1'b1);
    tick;

    // Reset mid-MUL abandons the operation
    req_in0[3*DW +: DW] = 8'd9;
    req_in1[3*DW +: DW] = 8'h85;
    req_valid = 4'b1000;
    #1;
    check("rst_op_grant", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    tick;
    tick;
    tick;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_out", rsp_out, 0);
    check("midrst_rsp_id", rsp_id, 0);
    check("midrst_rsp_overflow", rsp_overflow, 0);
    check("midrst_rsp_sig_ov", rsp_sig_ov, 0);
    tick;
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (rsp_valid) seen++;
      tick;
    end
    check("no_rsp_after_rst", seen, 0);
    req_valid = 4'b1100;
    #1;
    check("first_grant_after_rst", req_ready, 4'b0100);
    tick;
    req_valid = 4'b1000;
    wait_rsp(lat);
    check("req2b_latency", lat, 9);
    check_rsp(2, 8'hFF, 8'h01, 1'b1);
    tick;
    check("req3_grant", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    wait_rsp(lat);
    check("req3_latency", lat, 9);
    check_rsp(3, 8'hFF, 8'h04, 1'b1);
    tick;

    // Round robin with all requesters asserting; multipliers have MSB set
    for (int i = 0; i < NR; i++) begin
      req_in0[i*DW +: DW] = 8'(i + 1);
      req_in1[i*DW +: DW] = 8'(8'h80 + i);
    end
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == '0 && n < 30) begin
        tick;
        n++;
      end
      check("rr_grant", req_ready, 32'(1 << (g % NR)));
      if (g > 0) check("rr_interval", cyc - prev, 10);
      prev = cyc;
      tick;
    end
    req_valid = '0;
    wait_rsp(lat);
    check("rr_last_latency", lat, 9);
    check_rsp(0, 8'd128, 8'h00, 1'b0);
    tick;
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
